fetch_stage: RTL

- Instruction fetch stage that sits directly upstream of decode.
- Owns the PC, issues requests to instruction memory and buffers returned words in a small in-order FIFO.
- Presents {instr, pc, pc+4} to the decode stage with a valid/ready handshake.
- Supports redirect (branch/jump/jalr target from execute), which discards all buffered and in-flight fetches.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order instruction memory requests under a
// credit limit, and buffers returned words for decode. A redirect flushes buffered and in-flight work.
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pcplus4_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;

    localparam cnt_t FULL    = cnt_t'(DEPTH);
    localparam sum_t DEPTH_S = sum_t'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   tag_mem [DEPTH];
    logic [AW-1:0] tag_wr;
    logic [AW-1:0] tag_rd;
    cnt_t          outstanding;
    cnt_t          out_next;
    cnt_t          discard;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pcbuf_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    cnt_t          occ;

    sum_t          in_use;
    logic          grant;
    logic          push;
    logic          pop;
    logic          redirect_lsb_unused;

    // Buffered plus in-flight words never exceed DEPTH, so a response always finds a free slot.
    assign in_use      = {1'b0, occ} + {1'b0, outstanding};
    assign imem_req_o  = rst_n && !redirect_i && (in_use < DEPTH_S);
    assign imem_addr_o = pc;
    assign grant       = imem_req_o && imem_gnt_i;

    assign push       = imem_rvalid_i && (discard == '0) && !redirect_i;
    assign id_valid_o = (occ != '0) && !redirect_i;
    assign pop        = id_valid_o && id_ready_i;

    assign id_instr_o   = instr_mem[rd_ptr];
    assign id_pc_o      = pcbuf_mem[rd_ptr];
    assign id_pcplus4_o = id_pc_o + 32'd4;

    assign redirect_lsb_unused = ^redirect_pc_i[1:0];

    always_comb begin
        out_next = outstanding;
        if (grant && !imem_rvalid_i) begin
            out_next = outstanding + 1'b1;
        end else if (!grant && imem_rvalid_i) begin
            out_next = outstanding - 1'b1;
        end
    end

    // Control state: PC, in-flight bookkeeping and FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
        end else begin
            if (grant) begin
                tag_wr <= tag_wr + 1'b1;
            end
            if (imem_rvalid_i) begin
                tag_rd <= tag_rd + 1'b1;
            end
            outstanding <= out_next;
            if (redirect_i) begin
                // Every response still owed after this cycle belongs to the old path.
                pc      <= {redirect_pc_i[31:2], 2'b00};
                discard <= out_next;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                occ     <= '0;
            end else begin
                if (grant) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rvalid_i && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Data storage: request PC tags and buffered {instr, pc}.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[tag_wr] <= pc;
        end
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata_i;
            pcbuf_mem[wr_ptr] <= tag_mem[tag_rd];
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (occ == FULL)));
    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid_i && (outstanding == '0)));
`endif

endmodule
